// File: rtl/uvmt_axis_st_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter slice.
package uvmt_axis_st_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/uvmt_axis_st_rr_sel.sv
// Combinational round-robin picker: first requester after last_gnt, wrapping.
module uvmt_axis_st_rr_sel #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // Scan from the farthest candidate to the nearest so the nearest requester is the final assignment.
    always_comb begin
        logic [IDX_W-1:0] idx;
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = IDX_W'((int'(last_gnt) + k) % NUM_SRC);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uvmt_axis_st_pkt_arb.sv
// Packet-granular round-robin merge of NUM_SRC AXI-Stream sources onto one master stream.
// A grant is held from the first beat until the tlast handshake, with one idle cycle for arbitration.
module uvmt_axis_st_pkt_arb
    import uvmt_axis_st_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(NUM_SRC),
    localparam int KEEP_W     = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             s_tvalid,
    output logic [NUM_SRC-1:0]             s_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]      s_tkeep,
    input  logic [NUM_SRC-1:0]             s_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic [KEEP_W-1:0]              m_tkeep,
    output logic                           m_tlast,
    input  logic                           enable,
    output logic [IDX_W-1:0]               gnt_id,
    output logic                           busy,
    output logic [PKT_CNT_W-1:0]           pkt_cnt
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                   sel_valid;
    logic [IDX_W-1:0]       sel_winner;
    logic                   xfer_active;
    logic                   last_beat;

    uvmt_axis_st_rr_sel #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_sel (
        .req      (s_tvalid),
        .last_gnt (last_gnt_q),
        .valid    (sel_valid),
        .winner   (sel_winner)
    );

    // Reset gates the datapath so a packet cut short by reset loses no beat on the reset edge.
    assign xfer_active = (state_q == XFER) && !reset;

    always_comb begin
        m_tdata  = s_tdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep  = s_tkeep[gnt_q*KEEP_W +: KEEP_W];
        m_tvalid = xfer_active & s_tvalid[gnt_q];
        m_tlast  = xfer_active & s_tlast[gnt_q];
        s_tready = '0;
        if (xfer_active) begin
            s_tready[gnt_q] = m_tready;
        end
    end

    assign last_beat = m_tvalid & m_tready & m_tlast;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && sel_valid) begin
                    state_d = XFER;
                    gnt_d   = sel_winner;
                end
            end
            XFER: begin
                if (last_beat) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                    pkt_cnt_d  = pkt_cnt_q + PKT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_gnt resets to the top index so source 0 is first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IDX_W'(NUM_SRC - 1);
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign gnt_id  = gnt_q;
    assign busy    = (state_q == XFER);
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_uvmt_axis_st_pkt_arb.sv
// Self-checking bench for uvmt_axis_st_pkt_arb: per-source packet queues, directed scenarios and a
// randomized run compared with a packet-level round-robin reference model.
module tb_uvmt_axis_st_pkt_arb;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 2;

    typedef struct packed {
        logic          first;
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NS-1:0]    s_tvalid = '0;
    logic [NS-1:0]    s_tready;
    logic [NS*DW-1:0] s_tdata = '0;
    logic [NS*KW-1:0] s_tkeep = '0;
    logic [NS-1:0]    s_tlast = '0;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast;
    logic             enable = 1'b0;
    logic [IW-1:0]    gnt_id;
    logic             busy;
    logic [15:0]      pkt_cnt;

    int   total = 0;
    int   bad = 0;
    logic resetNext = 1'b1;
    logic enableNext = 1'b0;
    logic mReadyNext = 1'b0;
    bit   mReadyRandom = 1'b0;
    bit   gapsOn = 1'b0;

    beat_t srcq [NS][$];
    beat_t outq [$];
    int    outSrc [$];

    always #5 clk = ~clk;

    uvmt_axis_st_pkt_arb #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .enable   (enable),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    function automatic bit anyPending();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic addPkt(input int src, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.first = (k == 0);
            b.last  = (k == len - 1);
            b.keep  = KW'($urandom_range(1, 15));
            b.data  = base + DW'(k);
            srcq[src].push_back(b);
        end
    endtask

    // One clock: drive sources from their queues at the falling edge, then log the handshakes the
    // coming rising edge will complete; every accepted source beat must appear once on the master side.
    task automatic tick();
        int    nPop;
        bit    mFire;
        beat_t popped;
        beat_t seen;
        @(negedge clk);
        reset    = resetNext;
        enable   = enableNext;
        m_tready = mReadyRandom ? 1'($urandom_range(0, 1)) : mReadyNext;
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                s_tvalid[i]            = !(gapsOn && !srcq[i][0].first && ($urandom_range(0, 3) == 0));
                s_tdata[i*DW +: DW]    = srcq[i][0].data;
                s_tkeep[i*KW +: KW]    = srcq[i][0].keep;
                s_tlast[i]             = srcq[i][0].last;
            end else begin
                s_tvalid[i]            = 1'b0;
                s_tdata[i*DW +: DW]    = $urandom;
                s_tkeep[i*KW +: KW]    = KW'($urandom_range(0, 15));
                s_tlast[i]             = 1'($urandom_range(0, 1));
            end
        end
        #1;
        nPop   = 0;
        popped = '0;
        for (int i = 0; i < NS; i++) begin
            if (s_tvalid[i] && s_tready[i] && srcq[i].size() > 0) begin
                nPop++;
                popped = srcq[i].pop_front();
            end
        end
        mFire = m_tvalid && m_tready;
        if (mFire) begin
            seen = '{first: 1'b0, last: m_tlast, keep: m_tkeep, data: m_tdata};
            outq.push_back(seen);
            outSrc.push_back(int'(gnt_id));
        end
        if (nPop != 0 || mFire) begin
            total++;
            if (nPop != 1 || !mFire || m_tdata !== popped.data || m_tkeep !== popped.keep
                || m_tlast !== popped.last) begin
                bad++;
                $display("[TB] FAIL beat_integrity: pops=%0d m_fire=%0b data=%h keep=%h last=%b, required 1 pop, fire=1, data=%h keep=%h last=%b",
                         nPop, mFire, m_tdata, m_tkeep, m_tlast, popped.data, popped.keep, popped.last);
            end
        end
    endtask

    task automatic doReset();
        resetNext = 1'b1;
        tick();
        tick();
        resetNext = 1'b0;
        outq.delete();
        outSrc.delete();
    endtask

    task automatic drain(input string name, input int budget, output int cycles);
        cycles = 0;
        while ((anyPending() || busy) && cycles < budget) begin
            tick();
            cycles++;
        end
        total++;
        if (anyPending() || busy) begin
            bad++;
            $display("[TB] FAIL %s_timeout: still active after %0d cycles, required idle", name, cycles);
        end
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < NS; i++) srcq[i].delete();
        resetNext  = 1'b1;
        enableNext = 1'b1;
        mReadyNext = 1'b1;
        addPkt(1, 2, 32'h1000_0000);
        tick();
        tick();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (gnt_id !== 2'd0)   begin bad++; $display("[TB] FAIL reset_gnt: got %0d want 0", gnt_id); end
        total++; if (pkt_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_pkt_cnt: got %h want 0000", pkt_cnt); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
        total++; if (s_tready !== 4'h0) begin bad++; $display("[TB] FAIL reset_s_tready: got %b want 0000", s_tready); end
        resetNext  = 1'b0;
        enableNext = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL disabled_busy: got %b want 0", busy); end
        total++; if (s_tready !== 4'h0) begin bad++; $display("[TB] FAIL idle_s_tready: got %b want 0000", s_tready); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL idle_m_tvalid: got %b want 0", m_tvalid); end
        enableNext = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b1)     begin bad++; $display("[TB] FAIL first_grant_busy: got %b want 1", busy); end
        total++; if (gnt_id !== 2'd1)   begin bad++; $display("[TB] FAIL first_grant_id: got %0d want 1", gnt_id); end
        drain("reset", 50, n);
    endtask

    task automatic test_round_robin();
        int n;
        int order[$];
        int expOrder[5] = '{0, 1, 2, 3, 0};
        doReset();
        enableNext = 1'b1;
        mReadyNext = 1'b1;
        addPkt(0, 2, 32'h2000_0000);
        addPkt(0, 2, 32'h2000_0100);
        addPkt(1, 2, 32'h2100_0000);
        addPkt(2, 2, 32'h2200_0000);
        addPkt(3, 2, 32'h2300_0000);
        drain("rr", 100, n);
        for (int k = 0; k < outq.size(); k++) begin
            if (outq[k].last) order.push_back(outSrc[k]);
        end
        total++; if (order.size() != 5) begin bad++; $display("[TB] FAIL rr_pkts: got %0d want 5", order.size()); end
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            total++;
            if (order[k] != expOrder[k]) begin
                bad++;
                $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", k, order[k], expOrder[k]);
            end
        end
        total++; if (pkt_cnt !== 16'd5) begin bad++; $display("[TB] FAIL rr_pkt_cnt: got %0d want 5", pkt_cnt); end
        total++; if (n != 16) begin bad++; $display("[TB] FAIL rr_cycles: got %0d want 16", n); end
    endtask

    task automatic test_stall();
        logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        doReset();
        enableNext = 1'b1;
        mReadyNext = 1'b0;
        addPkt(2, 3, 32'hA5A5_00A0);
        tick();
        total++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 4'h0) begin
            bad++;
            $display("[TB] FAIL stall_arb_cycle: busy=%b m_tvalid=%b s_tready=%b want 0,0,0000", busy, m_tvalid, s_tready);
        end
        for (int k = 0; k < 5; k++) begin
            mReadyNext = pat[k];
            tick();
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL stall_busy[%0d]: got %b want 1", k, busy); end
            total++;
            if ((s_tready & 4'b1011) !== 4'h0) begin
                bad++;
                $display("[TB] FAIL stall_other_ready[%0d]: got %b want 0 on 0,1,3", k, s_tready);
            end
            total++;
            if (s_tready[2] !== pat[k]) begin
                bad++;
                $display("[TB] FAIL stall_ready2[%0d]: got %b want %b", k, s_tready[2], pat[k]);
            end
        end
        total++; if (outq.size() != 3) begin bad++; $display("[TB] FAIL stall_beats: got %0d want 3", outq.size()); end
        for (int k = 0; k < 3 && k < outq.size(); k++) begin
            total++;
            if (outq[k].data !== 32'hA5A5_00A0 + DW'(k) || outq[k].last !== (k == 2)) begin
                bad++;
                $display("[TB] FAIL stall_beat[%0d]: got data=%h last=%b want data=%h last=%b",
                         k, outq[k].data, outq[k].last, 32'hA5A5_00A0 + DW'(k), (k == 2));
            end
        end
        tick();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL stall_done_busy: got %b want 0", busy); end
        total++; if (pkt_cnt !== 16'd1) begin bad++; $display("[TB] FAIL stall_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_enable_drop();
        int n;
        doReset();
        enableNext = 1'b1;
        mReadyNext = 1'b1;
        addPkt(1, 4, 32'hB000_0000);
        tick();
        tick();
        enableNext = 1'b0;
        tick();
        tick();
        tick();
        total++; if (outq.size() != 4) begin bad++; $display("[TB] FAIL endrop_beats: got %0d want 4", outq.size()); end
        addPkt(3, 1, 32'hC000_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (busy !== 1'b0 || s_tready !== 4'h0) begin
                bad++;
                $display("[TB] FAIL endrop_hold[%0d]: busy=%b s_tready=%b want 0,0000", k, busy, s_tready);
            end
        end
        total++; if (pkt_cnt !== 16'd1) begin bad++; $display("[TB] FAIL endrop_pkt_cnt: got %0d want 1", pkt_cnt); end
        enableNext = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL endrop_arb: got %b want 0", busy); end
        tick();
        total++;
        if (busy !== 1'b1 || gnt_id !== 2'd3) begin
            bad++;
            $display("[TB] FAIL endrop_regrant: busy=%b gnt=%0d want 1,3", busy, gnt_id);
        end
        drain("endrop", 50, n);
    endtask

    task automatic test_reset_mid();
        int n;
        doReset();
        enableNext = 1'b1;
        mReadyNext = 1'b1;
        addPkt(0, 1, 32'hD000_0000);
        drain("rmid_pre", 50, n);
        addPkt(2, 5, 32'hE000_0000);
        tick();
        tick();
        total++;
        if (busy !== 1'b1 || gnt_id !== 2'd2) begin
            bad++;
            $display("[TB] FAIL rmid_grant: busy=%b gnt=%0d want 1,2", busy, gnt_id);
        end
        resetNext = 1'b1;
        tick();
        total++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'h0) begin
            bad++;
            $display("[TB] FAIL rmid_reset_cycle: m_tvalid=%b s_tready=%b want 0,0000", m_tvalid, s_tready);
        end
        resetNext = 1'b0;
        srcq[2].delete();
        addPkt(1, 1, 32'hE100_0000);
        addPkt(0, 1, 32'hE000_1000);
        tick();
        total++; if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_m_tvalid: got %b want 0", m_tvalid); end
        total++; if (pkt_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rmid_pkt_cnt: got %0d want 0", pkt_cnt); end
        tick();
        total++;
        if (busy !== 1'b1 || gnt_id !== 2'd0) begin
            bad++;
            $display("[TB] FAIL rmid_next_grant: busy=%b gnt=%0d want 1,0", busy, gnt_id);
        end
        drain("rmid", 50, n);
    endtask

    task automatic test_wrap();
        int n;
        enableNext = 1'b1;
        mReadyNext = 1'b1;
        force dut.pkt_cnt_q = 16'hFFFF;
        tick();
        release dut.pkt_cnt_q;
        tick();
        total++; if (pkt_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_preload: got %h want ffff", pkt_cnt); end
        addPkt(3, 1, 32'hF000_0000);
        drain("wrap", 50, n);
        total++; if (pkt_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_pkt_cnt: got %h want 0000", pkt_cnt); end
    endtask

    task automatic test_back_to_back();
        logic expBusy[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int   expGnt[5]  = '{0, 1, 0, 3, 0};
        doReset();
        enableNext = 1'b1;
        mReadyNext = 1'b1;
        addPkt(3, 1, 32'h3333_0000);
        addPkt(1, 1, 32'h1111_0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (busy !== expBusy[k]) begin
                bad++;
                $display("[TB] FAIL b2b_busy[%0d]: got %b want %b", k, busy, expBusy[k]);
            end
            if (expBusy[k]) begin
                total++;
                if (int'(gnt_id) != expGnt[k] || m_tvalid !== 1'b1 || m_tlast !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_beat[%0d]: gnt=%0d valid=%b last=%b want %0d,1,1",
                             k, gnt_id, m_tvalid, m_tlast, expGnt[k]);
                end
            end
        end
    endtask

    // Reference: with every pending source asserting tvalid on its first beat, the packet order is
    // plain round-robin over non-empty per-source FIFOs, starting after source NS-1.
    task automatic test_random_traffic();
        beat_t modelQ [NS][$];
        beat_t expQ [$];
        int    expSrc [$];
        int    last;
        int    s;
        int    nPkts;
        int    n;
        beat_t b;
        for (int round = 0; round < 4; round++) begin
            doReset();
            enableNext   = 1'b1;
            mReadyRandom = 1'b1;
            gapsOn       = 1'b1;
            expQ.delete();
            expSrc.delete();
            for (int i = 0; i < NS; i++) begin
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    addPkt(i, $urandom_range(1, 4), $urandom);
                end
                modelQ[i] = srcq[i];
            end
            last  = NS - 1;
            nPkts = 0;
            forever begin
                s = -1;
                for (int k = 1; k <= NS; k++) begin
                    if (s < 0 && modelQ[(last + k) % NS].size() > 0) s = (last + k) % NS;
                end
                if (s < 0) break;
                do begin
                    b = modelQ[s].pop_front();
                    expQ.push_back(b);
                    expSrc.push_back(s);
                end while (!b.last);
                last = s;
                nPkts++;
            end
            drain("rand", 1000, n);
            total++;
            if (outq.size() != expQ.size()) begin
                bad++;
                $display("[TB] FAIL rand_beats[r%0d]: got %0d want %0d", round, outq.size(), expQ.size());
            end
            for (int k = 0; k < expQ.size() && k < outq.size(); k++) begin
                total++;
                if (outq[k].data !== expQ[k].data || outq[k].keep !== expQ[k].keep
                    || outq[k].last !== expQ[k].last || outSrc[k] != expSrc[k]) begin
                    bad++;
                    $display("[TB] FAIL rand_beat[r%0d:%0d]: got src=%0d data=%h keep=%h last=%b want src=%0d data=%h keep=%h last=%b",
                             round, k, outSrc[k], outq[k].data, outq[k].keep, outq[k].last,
                             expSrc[k], expQ[k].data, expQ[k].keep, expQ[k].last);
                end
            end
            total++;
            if (int'(pkt_cnt) != nPkts) begin
                bad++;
                $display("[TB] FAIL rand_pkt_cnt[r%0d]: got %0d want %0d", round, pkt_cnt, nPkts);
            end
        end
        mReadyRandom = 1'b0;
        gapsOn       = 1'b0;
    endtask

    initial begin
        $display("[TB] starting uvmt_axis_st_pkt_arb bench");
        test_reset();
        test_round_robin();
        test_stall();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uvmt_axis_st_pkt_arb.md
UVMT_AXIS_ST_PKT_ARB -- requirements
Module: uvmt_axis_st_pkt_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, 4, number of AXI-Stream slave ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, 32, tdata width in bits (multiple of 8).
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port s_tvalid  input  NUM_SRC  per-source valid.
REQ-005 SHALL have port s_tready  output  NUM_SRC  per-source ready.
REQ-006 SHALL have port s_tdata  input  NUM_SRC*DATA_WIDTH  per-source data; source i occupies slice i.
REQ-007 SHALL have port s_tkeep  input  NUM_SRC*DATA_WIDTH/8  per-source byte keep.
REQ-008 SHALL have port s_tlast  input  NUM_SRC  per-source end of packet.
REQ-009 SHALL have ports:
- m_tvalid  output  1  merged stream valid.
- m_tready  input  1  merged stream ready.
- m_tdata  output  DATA_WIDTH  merged data.
- m_tkeep  output  DATA_WIDTH/8  merged keep.
- m_tlast  output  1  merged end of packet.
REQ-010 SHALL have port enable  input  1  permits new grants.
REQ-011 SHALL have ports:
- gnt_id  output  $clog2(NUM_SRC)  source currently granted.
- busy  output  1  packet in progress.
- pkt_cnt  output  16  packets forwarded.

Function
REQ-012 SHALL implement FSM with states IDLE and XFER.
REQ-013 SHALL, in IDLE with enable=1 and any s_tvalid=1, pick a winner round-robin starting at (last_gnt+1) mod NUM_SRC, load gnt_id, and enter XFER next cycle.
REQ-014 SHALL impose exactly one cycle of arbitration latency: no output beat in the IDLE cycle.
REQ-015 SHALL, in XFER, drive m_tvalid/m_tdata/m_tkeep/m_tlast combinationally from source gnt_id. It SHALL drive s_tready[gnt_id]=m_tready and all other s_tready=0.
REQ-016 SHALL hold s_tready all 0 and m_tvalid=0 in IDLE.
REQ-017 SHALL lock the grant until a beat with m_tvalid&m_tready&m_tlast. On that edge it SHALL return to IDLE, set last_gnt=gnt_id, and increment pkt_cnt.
REQ-018 SHALL let pkt_cnt wrap from 0xFFFF to 0x0000.
REQ-019 SHALL make deassertion of enable during XFER not affect the current packet; no new grant is issued while enable=0.
REQ-020 SHALL keep the grant locked if the granted source drops s_tvalid mid-packet; m_tvalid follows it low.
REQ-021 SHALL handle a single-beat packet (tlast on first beat): one XFER cycle when m_tready=1, then IDLE.
REQ-022 SHALL drive busy=1 exactly in XFER.
REQ-023 SHALL ignore tvalid of non-granted sources and never drop or duplicate a beat.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, enter IDLE and set last_gnt=NUM_SRC-1 so source 0 wins first.
REQ-025 SHALL, on reset, clear gnt_id=0, pkt_cnt=0, busy=0, m_tvalid=0, and s_tready=0.
REQ-026 SHALL abandon a packet in progress on reset mid-packet, with no output beat in the reset cycle.

Structure
REQ-027 SHALL place the state enum and the pkt_cnt width constant in package uvmt_axis_st_pkg.
REQ-028 SHALL isolate round-robin selection in sub-module uvmt_axis_st_rr_sel: inputs req, last_gnt; outputs valid, winner; combinational.

Verification
REQ-029 SHALL verify: all 4 sources valid with 2-beat packets and m_tready=1 -> grant order 0,1,2,3,0, pkt_cnt=5 after 5 packets.
REQ-030 SHALL verify: only source 2 valid with a 3-beat packet and m_tready toggling 1,0,1,0,1 -> 3 beats out with data intact, tlast on the 3rd beat, s_tready[0,1,3]=0 throughout.
REQ-031 SHALL verify: enable dropped on the 2nd beat of a 4-beat packet -> packet completes, then busy=0 with no grant until enable=1.
REQ-032 SHALL verify: reset asserted on beat 2 of a 5-beat packet -> next cycle busy=0, m_tvalid=0, pkt_cnt=0, and next grant to source 0.
REQ-033 SHALL verify: pkt_cnt preloaded to 0xFFFF via forced traffic with one more packet -> pkt_cnt=0x0000.
REQ-034 SHALL verify: back-to-back single-beat packets from sources 1 and 3 -> each followed by one IDLE cycle, order 1 then 3.
